// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pulse_scheduler
// Description : Round-robin arbiter that shares one stretched pulse output
//               (fixed high time plus optional low guard gap) among N_REQ
//               single-cycle requesters, with per-requester merge/drop flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_scheduler #(
  parameter int N_REQ        = 4,
  parameter int PULSE_CYCLES = 65536,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic [N_REQ-1:0]                        req,
  input  logic                                    clr_drop,
  output logic                                    pulse_out,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                                    busy,
  output logic [N_REQ-1:0]                        pending,
  output logic [N_REQ-1:0]                        drop
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [N_REQ-1:0]   drop_q, drop_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     idx_sum;
  logic               grant;
  logic [N_REQ-1:0]   grant_mask;

  // Scan offsets from high to low so the nearest set bit at/after rr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (idx_sum >= (IDX_W + 1)'(N_REQ)) begin
        idx_sum = idx_sum - (IDX_W + 1)'(N_REQ);
      end
      if (pending_q[idx_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant      = (state_q == ST_IDLE) && en && win_found;
    grant_mask = grant ? (N_REQ'(1) << win_idx) : '0;
    // A request on the winner's own grant edge re-arms it without a drop.
    pending_d  = (pending_q & ~grant_mask) | req;
    drop_d     = (clr_drop ? '0 : drop_q) | (req & pending_q & ~grant_mask);

    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          grant_d = win_idx;
          rr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          cnt_d   = '0;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          pulse_d = 1'b0;
          cnt_d   = '0;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign pulse_out = pulse_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_scheduler
// Description : Directed vector table plus hand-written corner sequences for
//               pulse_scheduler (N_REQ=4, PULSE_CYCLES=4, GAP_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       clr_drop;
  logic       pulse_out;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] drop;

  int n_checks = 0;
  int n_pass   = 0;

  pulse_scheduler #(
    .N_REQ       (4),
    .PULSE_CYCLES(4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .clr_drop (clr_drop),
    .pulse_out(pulse_out),
    .grant_id (grant_id),
    .busy     (busy),
    .pending  (pending),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       clr;
    logic       pulse;
    logic [1:0] gid;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] drop;
  } vec_t;

  vec_t vecs[24];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic p, input logic [1:0] g,
                         input logic b, input logic [3:0] pe, input logic [3:0] d);
    chk({tag, ".pulse"},   32'(pulse_out), 32'(p));
    chk({tag, ".grant"},   32'(grant_id),  32'(g));
    chk({tag, ".busy"},    32'(busy),      32'(b));
    chk({tag, ".pending"}, 32'(pending),   32'(pe));
    chk({tag, ".drop"},    32'(drop),      32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; en = 1'b1; clr_drop = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // req, en, clr | pulse, gid, busy, pending, drop (values after the edge)
    vecs[0]  = '{4'b1111, 1, 0, 0, 2'd0, 0, 4'b1111, 4'b0000};
    vecs[1]  = '{4'b0000, 1, 0, 1, 2'd0, 1, 4'b1110, 4'b0000};
    vecs[2]  = '{4'b0010, 1, 0, 1, 2'd0, 1, 4'b1110, 4'b0010};
    vecs[3]  = '{4'b0000, 1, 0, 1, 2'd0, 1, 4'b1110, 4'b0010};
    vecs[4]  = '{4'b0000, 1, 0, 1, 2'd0, 1, 4'b1110, 4'b0010};
    vecs[5]  = '{4'b0000, 1, 0, 0, 2'd0, 1, 4'b1110, 4'b0010};
    vecs[6]  = '{4'b0000, 1, 0, 0, 2'd0, 1, 4'b1110, 4'b0010};
    vecs[7]  = '{4'b0000, 1, 0, 0, 2'd0, 0, 4'b1110, 4'b0010};
    vecs[8]  = '{4'b0000, 1, 0, 1, 2'd1, 1, 4'b1100, 4'b0010};
    vecs[9]  = '{4'b0000, 1, 1, 1, 2'd1, 1, 4'b1100, 4'b0000};
    vecs[10] = '{4'b0000, 1, 0, 1, 2'd1, 1, 4'b1100, 4'b0000};
    vecs[11] = '{4'b0000, 1, 0, 1, 2'd1, 1, 4'b1100, 4'b0000};
    vecs[12] = '{4'b0000, 1, 0, 0, 2'd1, 1, 4'b1100, 4'b0000};
    vecs[13] = '{4'b0000, 1, 0, 0, 2'd1, 1, 4'b1100, 4'b0000};
    vecs[14] = '{4'b0000, 1, 0, 0, 2'd1, 0, 4'b1100, 4'b0000};
    vecs[15] = '{4'b0000, 1, 0, 1, 2'd2, 1, 4'b1000, 4'b0000};
    vecs[16] = '{4'b1000, 1, 1, 1, 2'd2, 1, 4'b1000, 4'b1000};
    vecs[17] = '{4'b0000, 1, 0, 1, 2'd2, 1, 4'b1000, 4'b1000};
    vecs[18] = '{4'b0000, 1, 0, 1, 2'd2, 1, 4'b1000, 4'b1000};
    vecs[19] = '{4'b0000, 1, 0, 0, 2'd2, 1, 4'b1000, 4'b1000};
    vecs[20] = '{4'b0000, 1, 0, 0, 2'd2, 1, 4'b1000, 4'b1000};
    vecs[21] = '{4'b0000, 0, 0, 0, 2'd2, 0, 4'b1000, 4'b1000};
    vecs[22] = '{4'b0000, 0, 0, 0, 2'd2, 0, 4'b1000, 4'b1000};
    vecs[23] = '{4'b0000, 1, 0, 1, 2'd3, 1, 4'b0000, 4'b1000};

    do_reset();
    chk_all("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);

    // Round-robin, merge/drop, clear-vs-set, enable hold.
    for (int i = 0; i < 24; i++) begin
      req = vecs[i].req; en = vecs[i].en; clr_drop = vecs[i].clr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].gid, vecs[i].busy,
              vecs[i].pend, vecs[i].drop);
    end
    req = '0; en = 1'b1; clr_drop = 1'b0;

    // Single request: 4 high cycles, 2 gap cycles, busy drops after the gap.
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    chk("single.pend", 32'(pending), 32'h4);
    chk("single.pulse0", 32'(pulse_out), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("single.pulse%0d", i), 32'(pulse_out), 32'((i >= 1 && i <= 4) ? 1 : 0));
      chk($sformatf("single.busy%0d", i),  32'(busy),      32'((i <= 6) ? 1 : 0));
      chk($sformatf("single.gid%0d", i),   32'(grant_id),  32'h2);
    end

    // Re-arm: request on own grant edge queues a second pulse after the gap.
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req = '0;
    chk("rearm.pend", 32'(pending), 32'h1);
    chk("rearm.drop", 32'(drop), 32'h0);
    chk("rearm.pulse", 32'(pulse_out), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("rearm.pulse%0d", i), 32'(pulse_out), 32'((i <= 4 || i == 8) ? 1 : 0));
    end
    chk("rearm.pend_end", 32'(pending), 32'h0);
    chk("rearm.gid_end", 32'(grant_id), 32'h0);

    // Reset mid-pulse clears everything and restarts the rr pointer.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    chk("rstmid.drop_pre", 32'(drop), 32'h4);
    chk("rstmid.pulse_pre", 32'(pulse_out), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_all("rstmid", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
    req = 4'b1010;
    tick();
    req = '0;
    chk("rstmid.pend", 32'(pending), 32'hA);
    tick();
    chk("rstmid.gid", 32'(grant_id), 32'h1);
    chk("rstmid.pulse", 32'(pulse_out), 32'h1);
    chk("rstmid.pend2", 32'(pending), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
